// File: rtl/io_uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state types for io_uart.
package io_uart_pkg;

  localparam logic [31:0] UART_STATUS = 32'h0;
  localparam logic [31:0] UART_RXDATA = 32'h4;
  localparam logic [31:0] UART_TXDATA = 32'h8;

  localparam int unsigned STATUS_TX_READY    = 0;
  localparam int unsigned STATUS_RX_VALID    = 1;
  localparam int unsigned STATUS_RX_OVERRUN  = 2;
  localparam int unsigned STATUS_FRAME_ERROR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/io_uart_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: TX shifter, RX sampler with receive FIFO, and STATUS/RXDATA/TXDATA decode.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'h18,
  parameter int unsigned BAUD_DIVIDE   = 434,
  parameter int unsigned RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int unsigned   CW        = $clog2(BAUD_DIVIDE);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIVIDE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIVIDE / 2 - 1);

  logic sel_status, sel_rxdata, sel_txdata;
  assign sel_status = (io_address == BASE_ADDRESS + UART_STATUS);
  assign sel_rxdata = (io_address == BASE_ADDRESS + UART_RXDATA);
  assign sel_txdata = (io_address == BASE_ADDRESS + UART_TXDATA);

  logic unused_write_bits;
  assign unused_write_bits = ^io_write_data[31:8];

  // Transmitter
  tx_state_t     tx_state;
  logic [CW-1:0] tx_count;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_ready;

  assign tx_ready = (tx_state == TX_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_count <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (io_write_en && sel_txdata) begin
            tx_state <= TX_START;
            tx_count <= BAUD_LAST;
            tx_shift <= io_write_data[7:0];
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_count == '0) begin
            tx_state <= TX_DATA;
            tx_count <= BAUD_LAST;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_count <= tx_count - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_count == '0) begin
            tx_count <= BAUD_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_count <= tx_count - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_count == '0) tx_state <= TX_IDLE;
          else                tx_count <= tx_count - 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver: a falling edge is seen as prev=1/now=0, so a line held low after a bad stop never re-triggers
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_count;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push;
  logic          rx_frame_set;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync      <= '1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_count     <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_push      <= 1'b0;
      rx_frame_set <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], uart_rx};
      rx_prev      <= rx_s;
      rx_push      <= 1'b0;
      rx_frame_set <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_count <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_count == '0) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_count <= BAUD_LAST;
              rx_bit   <= '0;
            end
          end else begin
            rx_count <= rx_count - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_count == '0) begin
            rx_count <= BAUD_LAST;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_count <= rx_count - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_count == '0) begin
            rx_state <= RX_IDLE;
            if (rx_s) rx_push      <= 1'b1;
            else      rx_frame_set <= 1'b1;
          end else begin
            rx_count <= rx_count - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [7:0] fifo_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  assign fifo_pop = io_read_en && sel_rxdata && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Register decode and sticky flags
  logic       rx_overrun;
  logic       rx_frame_error;
  logic       status_rd;
  logic       overrun_set;
  logic [3:0] status_bits;

  assign status_rd   = io_read_en && sel_status;
  assign overrun_set = rx_push && fifo_full && !fifo_pop;

  always_comb begin
    status_bits                     = '0;
    status_bits[STATUS_TX_READY]    = tx_ready;
    status_bits[STATUS_RX_VALID]    = !fifo_empty;
    status_bits[STATUS_RX_OVERRUN]  = rx_overrun;
    status_bits[STATUS_FRAME_ERROR] = rx_frame_error;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_read_data   <= '0;
      rx_overrun     <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      if (io_read_en) begin
        if (sel_status)      io_read_data <= {28'b0, status_bits};
        else if (sel_rxdata) io_read_data <= {24'b0, fifo_empty ? 8'h00 : fifo_data};
        else                 io_read_data <= '0;
      end
      // Later assignments win, so a same-cycle set overrides the read clear
      if (status_rd) begin
        rx_overrun     <= 1'b0;
        rx_frame_error <= 1'b0;
      end
      if (overrun_set)  rx_overrun     <= 1'b1;
      if (rx_frame_set) rx_frame_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Directed plus randomized bench for io_uart with BAUD_DIVIDE=8 against a queue-based reference model.
module tb_io_uart;
  localparam logic [31:0] A_ST = 32'h18;
  localparam logic [31:0] A_RX = 32'h1C;
  localparam logic [31:0] A_TX = 32'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_overrun = 1'b0;
  logic       m_frame   = 1'b0;

  io_uart #(.BAUD_DIVIDE(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    io_write_en   = 1'b1;
    io_address    = addr;
    io_write_data = data;
    tick(1);
    io_write_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    io_read_en = 1'b1;
    io_address = addr;
    tick(1);
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  // Called right after the accepted write; compares every cycle of the 10-bit frame
  task automatic check_tx_frame(input logic [7:0] data, input int extra_at, input logic [7:0] extra);
    logic [9:0] frame;
    logic [31:0] d;
    frame = {1'b1, data, 1'b0};
    for (int j = 0; j < 80; j++) begin
      check($sformatf("tx_bit%0d_cyc%0d", j / 8, j % 8), 32'(uart_tx), 32'(frame[j / 8]));
      if (j == extra_at) begin
        io_write_en   = 1'b1;
        io_address    = A_TX;
        io_write_data = {24'b0, extra};
      end
      if (j == extra_at + 1) io_write_en = 1'b0;
      if (j == 40) begin
        io_read_en = 1'b1;
        io_address = A_ST;
      end
      if (j == 41) begin
        io_read_en = 1'b0;
        check("tx_busy_status", io_read_data, 32'h0);
      end
      tick(1);
    end
    io_write_en = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check("tx_idle_after", 32'(uart_tx), 32'h1);
      tick(1);
    end
    bus_read(A_ST, d);
    check("tx_ready_after", d, 32'h1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(8);
    end
    uart_rx = stop;
    tick(8);
    uart_rx = 1'b1;
    tick(4);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    send_byte(d, stop);
    if (!stop)          m_frame = 1'b1;
    else if (q.size() == 8) m_overrun = 1'b1;
    else                q.push_back(d);
  endtask

  task automatic expect_status(input string tag);
    logic [31:0] d;
    bus_read(A_ST, d);
    check(tag, d, {28'b0, m_frame, m_overrun, q.size() != 0, 1'b1});
    m_frame   = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic expect_rxdata(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    bus_read(A_RX, d);
    e = (q.size() != 0) ? q.pop_front() : 8'h00;
    check(tag, d, {24'b0, e});
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    logic [7:0]  b;

    reset = 1'b1; io_write_en = 1'b0; io_read_en = 1'b0;
    io_address = '0; io_write_data = '0; uart_rx = 1'b1;
    tick(2);
    check("reset_uart_tx", 32'(uart_tx), 32'h1);
    check("reset_read_data", io_read_data, 32'h0);
    @(negedge clk); reset = 1'b0;
    tick(1);
    bus_read(A_ST, d);
    check("reset_status", d, 32'h1);

    // Transmit 'h41 and the busy / late-write cases
    bus_write(A_TX, 32'h41);
    check_tx_frame(8'h41, -1, 8'h00);
    bus_write(A_TX, 32'h55);
    check_tx_frame(8'h55, 9, 8'hAA);
    b = 8'($urandom);
    bus_write(A_TX, {24'b0, b});
    check_tx_frame(b, 79, 8'hC3);
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      bus_write(A_TX, {24'b0, b});
      check_tx_frame(b, -1, 8'h00);
    end

    // Writes to STATUS/RXDATA do nothing; unmapped reads return 0; read data holds
    bus_write(A_ST, 32'hFF);
    bus_write(A_RX, 32'h00);
    tick(3);
    check("no_tx_from_other_write", 32'(uart_tx), 32'h1);
    bus_read(A_ST, d);
    check("status_after_bad_writes", d, 32'h1);
    held = d;
    tick(5);
    check("read_data_holds", io_read_data, held);
    bus_read(A_TX, d);
    check("read_txdata_zero", d, 32'h0);
    bus_read(A_ST, d);
    bus_read(32'h100, d);
    check("read_unmapped_zero", d, 32'h0);

    // Receive 'h3C
    rx_frame(8'h3C, 1'b1);
    bus_read(A_ST, d);
    check("rx_status_valid", d, 32'h3);
    bus_read(A_RX, d);
    check("rx_data_3c", d, 32'h3C);
    void'(q.pop_front());
    bus_read(A_ST, d);
    check("rx_status_popped", d, 32'h1);

    // Overrun
    for (int k = 1; k <= 9; k++) rx_frame(8'(k), 1'b1);
    bus_read(A_ST, d);
    check("overrun_status", d, 32'h7);
    m_overrun = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus_read(A_RX, d);
      check($sformatf("overrun_data%0d", k), d, 32'(k));
      void'(q.pop_front());
    end
    bus_read(A_ST, d);
    check("overrun_cleared", d, 32'h1);
    bus_read(A_RX, d);
    check("rx_empty_read", d, 32'h0);

    // Glitch, then frame error
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(100);
    bus_read(A_ST, d);
    check("glitch_ignored", d, 32'h1);
    rx_frame(8'($urandom), 1'b0);
    bus_read(A_ST, d);
    check("frame_error_status", d, 32'h9);
    m_frame = 1'b0;
    bus_read(A_ST, d);
    check("frame_error_cleared", d, 32'h1);

    // Randomized receive traffic against the queue model
    for (int k = 0; k < 24; k++) begin
      rx_frame(8'($urandom), $urandom_range(0, 5) != 0);
      case ($urandom_range(0, 3))
        0:       expect_status("rand_status");
        1, 2:    expect_rxdata("rand_rxdata");
        default: ;
      endcase
    end
    expect_status("drain_status");
    for (int k = 0; k < 9; k++) expect_rxdata("drain_rxdata");
    expect_status("drain_final_status");

    // Reset in the middle of a TX frame with a byte waiting in the FIFO
    rx_frame(8'($urandom), 1'b1);
    bus_write(A_TX, 32'h00);
    tick(29);
    check("tx_low_before_reset", 32'(uart_tx), 32'h0);
    reset = 1'b1;
    #2;
    check("tx_high_on_reset", 32'(uart_tx), 32'h1);
    check("read_data_on_reset", io_read_data, 32'h0);
    q.delete();
    m_overrun = 1'b0;
    m_frame   = 1'b0;
    @(negedge clk); reset = 1'b0;
    tick(1);
    bus_read(A_ST, d);
    check("status_after_reset", d, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
